// File: rtl/conv_stream_driver.sv
// rtl/conv_stream_driver.sv - Serialises 24-bit vectors into 6-bit engine chunks and captures the result; CONV_CHECK_EN adds a result checker
module conv_stream_driver #(
   parameter int CHUNK_W       = 6,
   parameter int TAPS          = 4,
   parameter int RES_W         = 14,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_wsel,
   input  logic                      cmd_sample,
   input  logic [CHUNK_W*TAPS-1:0]   cmd_data,
   output logic [CHUNK_W-1:0]        chunk_out,
   output logic                      wsel_out,
   output logic                      link_step,
   input  logic [RES_W-1:0]          res_in,
   output logic [RES_W-1:0]          result,
   output logic                      result_valid,
   output logic                      busy
`ifdef CONV_CHECK_EN
   ,
   output logic                      check_err,
   output logic [RES_W-1:0]          exp_result
`endif
);

   localparam int VEC_W = CHUNK_W * TAPS;
   localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_SETTLE, ST_CAPTURE} state_t;

   state_t             state_q, state_d;
   logic [VEC_W-1:0]   data_q, data_d;
   logic               sample_q, sample_d;
   logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
   logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
   logic [CHUNK_W-1:0] chunk_out_q, chunk_out_d;
   logic               wsel_out_q, wsel_out_d;
   logic               link_step_q, link_step_d;
   logic [RES_W-1:0]   result_q, result_d;
   logic               result_valid_q, result_valid_d;

`ifdef CONV_CHECK_EN
   logic [VEC_W-1:0]   w_sh_q, w_sh_d;
   logic [VEC_W-1:0]   x_sh_q, x_sh_d;
   logic               upd_q, upd_d;
   logic [RES_W-1:0]   exp_max_q, exp_max_d;
   logic               check_err_q, check_err_d;
   logic [RES_W-1:0]   dot_sum, w_k, x_k;

   // Dot product of the shadow weight and input vectors (values never exceed RES_W bits)
   always_comb begin
      dot_sum = '0;
      w_k     = '0;
      x_k     = '0;
      for (int k = 0; k < TAPS; k++) begin
         w_k     = RES_W'(w_sh_q[k*CHUNK_W +: CHUNK_W]);
         x_k     = RES_W'(x_sh_q[k*CHUNK_W +: CHUNK_W]);
         dot_sum = dot_sum + w_k * x_k;
      end
   end

   assign check_err  = check_err_q;
   assign exp_result = exp_max_q;
`endif

   assign cmd_ready    = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign chunk_out    = chunk_out_q;
   assign wsel_out     = wsel_out_q;
   assign link_step    = link_step_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;

   // Next-state and next-output logic; chunk_out/wsel_out hold their value while idle
   always_comb begin
      state_d        = state_q;
      data_d         = data_q;
      sample_d       = sample_q;
      idx_d          = idx_q;
      idx_nxt        = idx_q + 1'b1;
      set_cnt_d      = set_cnt_q;
      chunk_out_d    = chunk_out_q;
      wsel_out_d     = wsel_out_q;
      link_step_d    = 1'b0;
      result_d       = result_q;
      result_valid_d = 1'b0;
`ifdef CONV_CHECK_EN
      w_sh_d         = w_sh_q;
      x_sh_d         = x_sh_q;
      upd_d          = 1'b0;
      exp_max_d      = exp_max_q;
      check_err_d    = check_err_q;
      // Running max absorbs the vector completed in the previous cycle
      if (upd_q && (dot_sum > exp_max_q)) begin
         exp_max_d = dot_sum;
      end
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               data_d      = cmd_data;
               wsel_out_d  = cmd_wsel;
               sample_d    = cmd_sample && !cmd_wsel;
               idx_d       = '0;
               chunk_out_d = cmd_data[CHUNK_W-1:0];
               link_step_d = 1'b1;
               state_d     = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (idx_q == IDX_W'(TAPS - 1)) begin
               set_cnt_d = '0;
               state_d   = sample_q ? ST_SETTLE : ST_IDLE;
`ifdef CONV_CHECK_EN
               if (wsel_out_q) begin
                  w_sh_d = data_q;
               end else begin
                  x_sh_d = data_q;
                  upd_d  = 1'b1;
               end
`endif
            end else begin
               idx_d       = idx_nxt;
               chunk_out_d = data_q[int'(idx_nxt)*CHUNK_W +: CHUNK_W];
               link_step_d = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
               state_d = ST_CAPTURE;
            end else begin
               set_cnt_d = set_cnt_q + 1'b1;
            end
         end
         ST_CAPTURE: begin
            result_d       = res_in;
            result_valid_d = 1'b1;
            state_d        = ST_IDLE;
`ifdef CONV_CHECK_EN
            if (res_in != exp_max_q) begin
               check_err_d = 1'b1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any partial vector
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         data_q         <= '0;
         sample_q       <= 1'b0;
         idx_q          <= '0;
         set_cnt_q      <= '0;
         chunk_out_q    <= '0;
         wsel_out_q     <= 1'b0;
         link_step_q    <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
`ifdef CONV_CHECK_EN
         w_sh_q         <= '0;
         x_sh_q         <= '0;
         upd_q          <= 1'b0;
         exp_max_q      <= '0;
         check_err_q    <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         data_q         <= data_d;
         sample_q       <= sample_d;
         idx_q          <= idx_d;
         set_cnt_q      <= set_cnt_d;
         chunk_out_q    <= chunk_out_d;
         wsel_out_q     <= wsel_out_d;
         link_step_q    <= link_step_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
`ifdef CONV_CHECK_EN
         w_sh_q         <= w_sh_d;
         x_sh_q         <= x_sh_d;
         upd_q          <= upd_d;
         exp_max_q      <= exp_max_d;
         check_err_q    <= check_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_conv_stream_driver.sv
// tb/tb_conv_stream_driver.sv - Bench for conv_stream_driver with an engine model and chunk/result scoreboards
module tb_conv_stream_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wsel;
   logic        cmd_sample;
   logic [23:0] cmd_data;
   logic [5:0]  chunk_out;
   logic        wsel_out;
   logic        link_step;
   logic [13:0] res_in;
   logic [13:0] result;
   logic        result_valid;
   logic        busy;
`ifdef CONV_CHECK_EN
   logic        check_err;
   logic [13:0] exp_result;
`endif

   conv_stream_driver dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_wsel     (cmd_wsel),
      .cmd_sample   (cmd_sample),
      .cmd_data     (cmd_data),
      .chunk_out    (chunk_out),
      .wsel_out     (wsel_out),
      .link_step    (link_step),
      .res_in       (res_in),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy)
`ifdef CONV_CHECK_EN
      ,
      .check_err    (check_err),
      .exp_result   (exp_result)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Engine model: four weight taps and four input taps, new chunk enters tap 3
   logic [23:0] eng_w, eng_x;
   logic [1:0]  eng_cnt;
   logic [13:0] eng_max;
   logic        ovr;

   function automatic logic [13:0] dot(input logic [23:0] w, input logic [23:0] x);
      logic [13:0] acc;
      acc = '0;
      for (int k = 0; k < 4; k++) acc = acc + 14'(w[k*6 +: 6]) * 14'(x[k*6 +: 6]);
      return acc;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         eng_w   <= '0;
         eng_x   <= '0;
         eng_cnt <= '0;
         eng_max <= '0;
      end else if (link_step) begin
         if (wsel_out) begin
            eng_w <= {chunk_out, eng_w[23:6]};
         end else begin
            eng_x   <= {chunk_out, eng_x[23:6]};
            eng_cnt <= eng_cnt + 2'd1;
            if (eng_cnt == 2'd3 && dot(eng_w, {chunk_out, eng_x[23:6]}) > eng_max)
               eng_max <= dot(eng_w, {chunk_out, eng_x[23:6]});
         end
      end
   end

   assign res_in = ovr ? 14'd5 : eng_max;

   // Scoreboards
   logic [6:0]  chunk_q[$];
   logic [13:0] res_q[$];
   time         acc_time;
   logic [6:0]  mon_c;
   logic [13:0] mon_r;

   always @(negedge clk) begin
      if (link_step) begin
         if (chunk_q.size() == 0) begin
            check("chunk_unexpected", 1, 0);
         end else begin
            mon_c = chunk_q.pop_front();
            check("chunk_out", int'(chunk_out), int'(mon_c[5:0]));
            check("wsel_out", int'(wsel_out), int'(mon_c[6]));
         end
      end
      if (result_valid) begin
         if (res_q.size() == 0) begin
            check("result_unexpected", 1, 0);
         end else begin
            mon_r = res_q.pop_front();
            check("result", int'(result), int'(mon_r));
            check("result_latency", int'(($time - acc_time + 5) / 10), 8);
         end
      end
   end

   task automatic send(input logic w, input logic s, input logic [23:0] d,
                       input int lat, input logic [13:0] res, input logic keep);
      int n;
      cmd_valid  = 1'b1;
      cmd_wsel   = w;
      cmd_sample = s;
      cmd_data   = d;
      for (int k = 0; k < 4; k++) chunk_q.push_back({w, d[k*6 +: 6]});
      if (s && !w) res_q.push_back(res);
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      acc_time = $time;
      #1;
      if (keep) begin
         cmd_wsel   = ~w;
         cmd_sample = 1'b1;
         cmd_data   = ~d;
      end else begin
         cmd_valid = 1'b0;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_ready && n < 100);
      check("ready_latency", n, lat);
   endtask

   typedef struct {
      logic        wsel;
      logic        sample;
      logic [23:0] data;
      int          lat;
      logic [13:0] res;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 1'b0, 24'hABCDEF, 5, 14'd0};
      tbl[1] = '{1'b1, 1'b0, 24'h041041, 5, 14'd0};
      tbl[2] = '{1'b0, 1'b1, 24'h0C30C3, 8, 14'd12};
      tbl[3] = '{1'b1, 1'b0, 24'hFFFFFF, 5, 14'd0};
      tbl[4] = '{1'b0, 1'b1, 24'hFFFFFF, 8, 14'd15876};
      tbl[5] = '{1'b0, 1'b1, 24'h000000, 8, 14'd15876};

      rst = 1'b1; cmd_valid = 1'b0; cmd_wsel = 1'b0; cmd_sample = 1'b0;
      cmd_data = '0; ovr = 1'b0; acc_time = 0;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_result", int'(result), 0);
      check("rst_result_valid", int'(result_valid), 0);
      check("rst_link_step", int'(link_step), 0);
      check("rst_chunk_out", int'(chunk_out), 0);

      // Table vectors: serialisation, latency and running max
      for (int i = 0; i < 6; i++) begin
         send(tbl[i].wsel, tbl[i].sample, tbl[i].data, tbl[i].lat, tbl[i].res, 1'b0);
`ifdef CONV_CHECK_EN
         if (tbl[i].sample && !tbl[i].wsel) begin
            check("exp_result", int'(exp_result), int'(tbl[i].res));
            check("check_err_clear", int'(check_err), 0);
         end
`endif
      end

      // Reset during SHIFT cycle 2
      cmd_valid = 1'b1; cmd_wsel = 1'b1; cmd_sample = 1'b0; cmd_data = 24'h5A3C96;
      for (int k = 0; k < 4; k++) chunk_q.push_back({1'b1, cmd_data[k*6 +: 6]});
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("abort_chunks_left", chunk_q.size(), 1);
      chunk_q.delete();
      @(negedge clk);
      check("abort_link_step", int'(link_step), 0);
      check("abort_chunk_out", int'(chunk_out), 0);
      check("abort_cmd_ready", int'(cmd_ready), 1);
      check("abort_busy", int'(busy), 0);
      send(1'b1, 1'b0, 24'h7E5C3A, 5, 14'd0, 1'b0);

      // cmd_valid held high across alternating commands
      send(1'b1, 1'b1, 24'h041041, 5, 14'd0, 1'b1);
      send(1'b0, 1'b1, 24'h0C30C3, 8, 14'd12, 1'b1);
      send(1'b1, 1'b1, 24'h041041, 5, 14'd0, 1'b1);
      ovr = 1'b1;
      send(1'b0, 1'b1, 24'h0C30C3, 8, 14'd5, 1'b0);
      ovr = 1'b0;
`ifdef CONV_CHECK_EN
      check("check_err_set", int'(check_err), 1);
      check("exp_result_hold", int'(exp_result), 12);
`endif
      send(1'b0, 1'b1, 24'h041041, 8, 14'd12, 1'b0);
`ifdef CONV_CHECK_EN
      check("check_err_sticky", int'(check_err), 1);
`endif
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst2_result", int'(result), 0);
      check("rst2_cmd_ready", int'(cmd_ready), 1);
`ifdef CONV_CHECK_EN
      check("rst2_check_err", int'(check_err), 0);
      check("rst2_exp_result", int'(exp_result), 0);
`endif

      repeat (3) @(negedge clk);
      check("chunk_q_empty", chunk_q.size(), 0);
      check("res_q_empty", res_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/conv_stream_driver.md
Name: conv_stream_driver

Overview:
Host-side transmitter for the 4-tap convolution/max-pool engine's load interface. Takes 24-bit weight or input vectors from a valid/ready command port and serialises each one as four 6-bit chunks, with a weight/input select line and a per-chunk step strobe. After an input load it optionally waits a settle period, then captures the engine's 14-bit running-max result. Sits between the test/host controller and the engine's ui_in/uio_in[7] pins, and reads back uo_out/uio_out[5:0].

Parameters:
CHUNK_W, 6, bits per chunk and per tap operand
TAPS, 4, chunks per vector; vector width = CHUNK_W*TAPS
RES_W, 14, width of engine result
SETTLE_CYCLES, 2, clk cycles waited after the last chunk before the result is sampled (minimum 1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_wsel  in  1  1 = vector is weights, 0 = inputs
cmd_sample  in  1  capture the result after the shift; ignored when cmd_wsel=1
cmd_data  in  24  vector; chunk k = cmd_data[6k+5:6k]
chunk_out  out  6  chunk to the engine's ui_in[5:0]
wsel_out  out  1  to the engine's uio_in[7]
link_step  out  1  chunk_out/wsel_out valid this cycle; integration advances the engine exactly once per asserted cycle
res_in  in  14  engine result {uio_out[5:0], uo_out}
result  out  14  last captured result
result_valid  out  1  one-cycle pulse when result updates
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, SHIFT, SETTLE, CAPTURE.
- Reset (rst=1 at a clk edge): state=IDLE, chunk_out=0, wsel_out=0, link_step=0, result=0, result_valid=0, busy=0, counters=0. cmd_ready=1 from the first cycle after reset. Reset overrides any state, including mid-SHIFT; a partial vector is abandoned and nothing is replayed.
- IDLE: cmd_ready=1, link_step=0, chunk_out and wsel_out hold their last values. On cmd_valid&&cmd_ready: latch cmd_data, cmd_wsel and (cmd_sample && !cmd_wsel); go to SHIFT with chunk index 0.
- SHIFT: exactly TAPS consecutive cycles with link_step=1.
  - Cycle k drives chunk_out = data[6k+5:6k], LSB chunk first, so that after four engine shifts chunk 0 sits in tap 0.
  - wsel_out = latched wsel for all TAPS cycles.
  - After cycle TAPS-1: go to SETTLE if the sample flag is set, otherwise IDLE.
- SETTLE: link_step=0; count SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE: one cycle. result <= res_in, result_valid=1 for this cycle, then go to IDLE.
- Latency:
  - accept to first link_step: 1 cycle.
  - accept to result_valid: 1+TAPS+SETTLE_CYCLES+1 = 8 cycles at defaults.
  - accept to the next cmd_ready: 5 cycles with no sample, 8 cycles with sample.
- cmd_valid while busy is ignored: no stall corruption and no queuing. Commands are back-to-back capable; the next accept can occur the cycle cmd_ready returns.
- No arithmetic is performed in the base block. res_in is captured verbatim.

Optional Feature:
Macro CONV_CHECK_EN.
- When defined:
  - Shadow 24-bit weight and input registers are updated at the end of each completed SHIFT.
  - An expected running max (14 bits, reset 0) is computed: exp_max = max(exp_max, sum over k of w_k*x_k), unsigned, 14-bit, never overflows (max 4*63*63 = 15876).
  - exp_max updates only after an input vector completes.
  - In CAPTURE, res_in != exp_max sets a sticky output check_err (1 bit, reset 0, cleared only by rst).
  - An extra output exp_result[13:0] exposes exp_max.
- When undefined: the check_err and exp_result ports, the shadow registers and the multipliers are absent.

Test Plan:
1. rst held 3 cycles, then released: cmd_ready=1, busy=0, result=0, result_valid=0, link_step=0.
2. cmd_wsel=1, cmd_data=24'hABCDEF: link_step high for 4 cycles with chunk_out 0x2F, 0x37, 0x3C, 0x2A and wsel_out=1; no result_valid; cmd_ready returns 5 cycles after accept.
3. Weights 24'h041041 (all chunks 1), then inputs 24'h0C30C3 (all chunks 3) with cmd_sample=1, engine model attached: result_valid pulses 8 cycles after the input accept with result=12; with CONV_CHECK_EN, exp_result=12 and check_err=0.
4. Weights 24'hFFFFFF, inputs 24'hFFFFFF, sample: result=0x3E04 (15876). Then inputs 24'h0, sample: result stays 0x3E04 (running max).
5. rst asserted during SHIFT cycle 2: the next cycle is IDLE, link_step=0, chunk_out=0, cmd_ready=1; a following weight command shifts all 4 chunks correctly.
6. cmd_valid held high continuously with alternating commands: exactly one accept per cmd_ready window, never overlapping SHIFT sequences; cmd_sample=1 with cmd_wsel=1 gives no SETTLE and no result_valid. With CONV_CHECK_EN, forcing res_in=5 against an expected value of 12 sets check_err=1, which stays set until rst.
